// File: rtl/danger_spawner_pkg.sv
// danger_spawner_pkg: obstacle type codes, sprite geometry, screen constants,
// spawner FSM states and the LFSR-to-type mapping shared by the spawner files.
package danger_spawner_pkg;

  typedef enum logic [2:0] {
    LOW_BIRD     = 3'd0,
    HIGH_BIRD    = 3'd1,
    SMALL_CACTUS = 3'd2,
    MANY_CACTUS  = 3'd3,
    BIG_CACTUS   = 3'd4,
    NOTHING      = 3'd5
  } danger_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } spawn_state_e;

  localparam int SCREEN_W = 640;
  localparam int GROUND   = 298;

  // Sprite geometry; the widest sprite (big cactus) sets the spawn x.
  localparam int BIRD_W         = 46;
  localparam int BIRD_H         = 40;
  localparam int SMALL_CACTUS_W = 17;
  localparam int SMALL_CACTUS_H = 35;
  localparam int MANY_CACTUS_W  = 51;
  localparam int MANY_CACTUS_H  = 35;
  localparam int BIG_CACTUS_W   = 77;
  localparam int BIG_CACTUS_H   = 50;

  localparam int SLOTS = 3;

  // Three random bits to an obstacle type; codes 5..7 fold back onto cacti.
  function automatic danger_type_e map_type(input logic [2:0] r);
    danger_type_e t;
    case (r)
      3'd0:    t = LOW_BIRD;
      3'd1:    t = HIGH_BIRD;
      3'd2:    t = SMALL_CACTUS;
      3'd3:    t = MANY_CACTUS;
      3'd4:    t = BIG_CACTUS;
      3'd5:    t = SMALL_CACTUS;
      3'd6:    t = MANY_CACTUS;
      default: t = BIG_CACTUS;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/danger_lfsr16.sv
// danger_lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
// Steps once per enabled cycle; reset loads SEED (must be nonzero).
module danger_lfsr16
  import danger_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];

  // Shift in the feedback bit on each enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {r_state[14:0], w_fb};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/danger_spawner.sv
// danger_spawner: owns three obstacle slots, scrolls them left by `speed`
// once per frame tick, retires those that leave the screen and spawns new
// ones at SPAWN_X with LFSR-chosen type and gap.
// Build option: define DANGER_BIRD_EN to allow bird types to spawn; without
// it, birds are remapped to cacti.
// Type and gap for a spawn are taken from the LFSR value before that tick's
// advance.
module danger_spawner
  import danger_spawner_pkg::*;
#(
  parameter int          SPAWN_X   = 717,
  parameter int          MIN_GAP   = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       clear,
  input  logic [3:0] speed,
  output logic [9:0] danger_pos1,
  output logic [9:0] danger_pos2,
  output logic [9:0] danger_pos3,
  output logic [2:0] danger_type1,
  output logic [2:0] danger_type2,
  output logic [2:0] danger_type3,
  output logic       danger_en1,
  output logic       danger_en2,
  output logic       danger_en3,
  output logic       spawn_pulse
);

  localparam int GAP_W = $clog2(MIN_GAP + 64);

  spawn_state_e     r_state;
  spawn_state_e     w_state_next;
  logic             w_step;
  logic [15:0]      w_lfsr;
  logic             w_unused_lfsr_hi;
  logic [GAP_W-1:0] r_gap;
  logic             r_spawn;
  logic             w_spawn;
  danger_type_e     w_mapped_type;
  danger_type_e     w_new_type;
  logic [9:0]       w_pos [SLOTS];
  danger_type_e     w_type [SLOTS];
  logic [SLOTS-1:0] w_en;
  logic [SLOTS-1:0] w_target;

  // Only the low nine bits pick type and gap; the rest only feed the sequence.
  assign w_unused_lfsr_hi = ^w_lfsr[15:9];

  danger_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_step),
    .o_state (w_lfsr)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: clear always wins, run=0 halts a running game.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (frame_tick && run) w_state_next = ST_RUN;
        ST_RUN:  if (!run)              w_state_next = ST_HALT;
        ST_HALT: if (frame_tick && run) w_state_next = ST_RUN;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // FSM output: a game step happens on any tick that lands in (or stays in) RUN.
  always_comb begin
    w_step = 1'b0;
    if (frame_tick && (w_state_next == ST_RUN)) begin
      w_step = 1'b1;
    end
  end

  assign w_mapped_type = map_type(w_lfsr[2:0]);

`ifdef DANGER_BIRD_EN
  assign w_new_type = w_mapped_type;
`else
  // Bird-free build: low bird becomes small cactus, high bird many cactus.
  always_comb begin
    w_new_type = w_mapped_type;
    if (w_mapped_type == LOW_BIRD) begin
      w_new_type = SMALL_CACTUS;
    end else if (w_mapped_type == HIGH_BIRD) begin
      w_new_type = MANY_CACTUS;
    end
  end
`endif

  // Occupancy is sampled before this tick's retirements, so a slot freed now
  // is only reused on a later tick.
  assign w_spawn = w_step && (r_gap == '0) && !(&w_en);

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      localparam logic [SLOTS-1:0] LOWER = SLOTS'((1 << gi) - 1);

      logic [9:0]   r_pos;
      danger_type_e r_type;
      logic         r_en;

      // Lowest-index free slot takes the spawn.
      assign w_target[gi] = w_spawn && !r_en && ((w_en & LOWER) == LOWER);

      // Per-slot spawn, scroll and retire; a fresh spawn is not moved.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pos  <= '0;
          r_type <= NOTHING;
          r_en   <= 1'b0;
        end else if (clear) begin
          r_pos  <= '0;
          r_type <= NOTHING;
          r_en   <= 1'b0;
        end else if (w_step) begin
          if (w_target[gi]) begin
            r_pos  <= 10'(SPAWN_X);
            r_type <= w_new_type;
            r_en   <= 1'b1;
          end else if (r_en) begin
            if (r_pos <= {6'd0, speed}) begin
              r_pos  <= '0;
              r_type <= NOTHING;
              r_en   <= 1'b0;
            end else begin
              r_pos <= r_pos - {6'd0, speed};
            end
          end
        end
      end

      assign w_pos[gi]  = r_pos;
      assign w_type[gi] = r_type;
      assign w_en[gi]   = r_en;
    end
  endgenerate

  // Gap counter and spawn strobe; the counter parks at zero while slots are full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap   <= GAP_W'(MIN_GAP);
      r_spawn <= 1'b0;
    end else if (clear) begin
      r_gap   <= GAP_W'(MIN_GAP);
      r_spawn <= 1'b0;
    end else begin
      r_spawn <= w_spawn;
      if (w_step) begin
        if (w_spawn) begin
          r_gap <= GAP_W'(MIN_GAP) + GAP_W'(w_lfsr[8:3]);
        end else if (r_gap != '0) begin
          r_gap <= r_gap - 1'b1;
        end
      end
    end
  end

  assign danger_pos1  = w_pos[0];
  assign danger_pos2  = w_pos[1];
  assign danger_pos3  = w_pos[2];
  assign danger_type1 = w_type[0];
  assign danger_type2 = w_type[1];
  assign danger_type3 = w_type[2];
  assign danger_en1   = w_en[0];
  assign danger_en2   = w_en[1];
  assign danger_en3   = w_en[2];
  assign spawn_pulse  = r_spawn;

endmodule

// File: tb/tb_danger_spawner.sv
// tb_danger_spawner: directed stimulus with a cycle-tagged scoreboard.
// The driver pushes expected outputs (from a behavioural model plus
// hand-computed slot-1 checkpoints); a monitor pops and compares them.
`timescale 1ns/1ps
module tb_danger_spawner;

  localparam int          T_SPAWN_X = 717;
  localparam int          T_MIN_GAP = 40;
  localparam logic [15:0] T_SEED    = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, frame_tick, run, clear;
  logic [3:0] speed;
  logic [9:0] danger_pos1, danger_pos2, danger_pos3;
  logic [2:0] danger_type1, danger_type2, danger_type3;
  logic       danger_en1, danger_en2, danger_en3, spawn_pulse;

  danger_spawner dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .run          (run),
    .clear        (clear),
    .speed        (speed),
    .danger_pos1  (danger_pos1),
    .danger_pos2  (danger_pos2),
    .danger_pos3  (danger_pos3),
    .danger_type1 (danger_type1),
    .danger_type2 (danger_type2),
    .danger_type3 (danger_type3),
    .danger_en1   (danger_en1),
    .danger_en2   (danger_en2),
    .danger_en3   (danger_en3),
    .spawn_pulse  (spawn_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          hand;
    bit          ht;
    bit          hp;
    logic [29:0] pos;
    logic [8:0]  typ;
    logic [2:0]  en;
    logic        pulse;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;
  logic [7:0] seen = 8'h00;

  // behavioural model state
  int          m_pos [3];
  int          m_type[3];
  bit          m_en  [3];
  int          m_gap;
  logic [15:0] m_lfsr;
  bit          m_pulse;
  int          tbl   [8];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, got, want);
    end
  endtask

  // Monitor: compare every expectation tagged for this cycle.
  always @(posedge clk) begin
    #2;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e_mon = q.pop_front();
      if (!e_mon.hand) begin
        chk("model.pos", e_mon.cyc, 32'({danger_pos3, danger_pos2, danger_pos1}), 32'(e_mon.pos));
        chk("model.type", e_mon.cyc, 32'({danger_type3, danger_type2, danger_type1}), 32'(e_mon.typ));
        chk("model.en", e_mon.cyc, 32'({danger_en3, danger_en2, danger_en1}), 32'(e_mon.en));
        chk("model.pulse", e_mon.cyc, 32'(spawn_pulse), 32'(e_mon.pulse));
      end else begin
        $display("hand %s cyc=%0d pos1=%0d en1=%0d type1=%0d pulse=%0d",
                 e_mon.name, e_mon.cyc, danger_pos1, danger_en1, danger_type1, spawn_pulse);
        chk({e_mon.name, ".pos1"}, e_mon.cyc, 32'(danger_pos1), 32'(e_mon.pos[9:0]));
        chk({e_mon.name, ".en1"}, e_mon.cyc, 32'(danger_en1), 32'(e_mon.en[0]));
        if (e_mon.ht) chk({e_mon.name, ".type1"}, e_mon.cyc, 32'(danger_type1), 32'(e_mon.typ[2:0]));
        if (e_mon.hp) chk({e_mon.name, ".pulse"}, e_mon.cyc, 32'(spawn_pulse), 32'(e_mon.pulse));
      end
    end
  end

  // Record every obstacle type that ever appears in an occupied slot.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (danger_en1) seen[danger_type1] = 1'b1;
      if (danger_en2) seen[danger_type2] = 1'b1;
      if (danger_en3) seen[danger_type3] = 1'b1;
    end
  end

  task automatic model_slots_empty();
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = 0; m_type[i] = 5; m_en[i] = 1'b0;
    end
    m_gap   = T_MIN_GAP;
    m_pulse = 1'b0;
  endtask

  task automatic model_update(input bit rs, input bit t, input bit r, input bit c, input logic [3:0] s);
    int tgt;
    int nt;
    int ng;
    if (rs) begin
      model_slots_empty();
      m_lfsr = T_SEED;
    end else if (c) begin
      model_slots_empty();
    end else begin
      m_pulse = 1'b0;
      if (t && r) begin
        tgt = -1;
        for (int i = 2; i >= 0; i--) if (!m_en[i]) tgt = i;
        nt = tbl[m_lfsr[2:0]];
        ng = T_MIN_GAP + int'(m_lfsr[8:3]);
        for (int i = 0; i < 3; i++) begin
          if (m_en[i]) begin
            if (m_pos[i] <= int'(s)) begin
              m_pos[i] = 0; m_type[i] = 5; m_en[i] = 1'b0;
            end else begin
              m_pos[i] = m_pos[i] - int'(s);
            end
          end
        end
        if (m_gap == 0 && tgt >= 0) begin
          m_pos[tgt] = T_SPAWN_X; m_type[tgt] = nt; m_en[tgt] = 1'b1;
          m_gap = ng;
          m_pulse = 1'b1;
        end else if (m_gap > 0) begin
          m_gap = m_gap - 1;
        end
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      end
    end
  endtask

  // One clock cycle of stimulus; the model expectation is tagged for the next edge.
  task automatic step(input bit rs, input bit t, input bit r, input bit c, input logic [3:0] s);
    exp_t e;
    @(negedge clk);
    rst = rs; frame_tick = t; run = r; clear = c; speed = s;
    model_update(rs, t, r, c, s);
    e.cyc   = cyc_cnt + 1;
    e.hand  = 1'b0;
    e.ht    = 1'b0;
    e.hp    = 1'b0;
    e.pos   = {10'(m_pos[2]), 10'(m_pos[1]), 10'(m_pos[0])};
    e.typ   = {3'(m_type[2]), 3'(m_type[1]), 3'(m_type[0])};
    e.en    = {m_en[2], m_en[1], m_en[0]};
    e.pulse = m_pulse;
    e.name  = "model";
    q.push_back(e);
  endtask

  // Hand-computed slot-1 checkpoint for the cycle of the last step.
  task automatic hand(input string nm, input int p, input bit en, input bit ht, input int ty,
                      input bit hp, input bit pu);
    exp_t e;
    e.cyc   = cyc_cnt + 1;
    e.hand  = 1'b1;
    e.ht    = ht;
    e.hp    = hp;
    e.pos   = {20'd0, 10'(p)};
    e.typ   = {6'd0, 3'(ty)};
    e.en    = {2'b00, en};
    e.pulse = pu;
    e.name  = nm;
    q.push_back(e);
  endtask

  task automatic ticks(input int n, input int per, input logic [3:0] s, input bit r);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, r, 1'b0, s);
      for (int j = 1; j < per; j++) step(1'b0, 1'b0, r, 1'b0, s);
    end
  endtask

  initial begin
`ifdef DANGER_BIRD_EN
    tbl = '{0, 1, 2, 3, 4, 2, 3, 4};
`else
    tbl = '{2, 3, 2, 3, 4, 2, 3, 4};
`endif
    rst = 1'b1; frame_tick = 1'b0; run = 1'b0; clear = 1'b0; speed = 4'd0;

    // reset state
    step(1, 0, 0, 0, 0); hand("reset", 0, 0, 1, 5, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // first spawn on tick 41, pulse lasts one cycle
    ticks(40, 10, 4'd4, 1'b1); hand("pre_spawn", 0, 0, 1, 5, 1, 0);
    step(0, 1, 1, 0, 4);       hand("spawn", T_SPAWN_X, 1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 4);       hand("pulse_end", T_SPAWN_X, 1, 0, 0, 1, 0);

    // slot 1 scroll: 717 - 47*15 = 12, hold at speed 0, 12-5=7, 7-6=1, 1<=1 retires
    ticks(47, 3, 4'd15, 1'b1); hand("move15", 12, 1, 0, 0, 0, 0);
    ticks(1, 3, 4'd0, 1'b1);   hand("speed0", 12, 1, 0, 0, 0, 0);
    ticks(1, 3, 4'd5, 1'b1);   hand("to7", 7, 1, 0, 0, 0, 0);
    ticks(1, 3, 4'd6, 1'b1);   hand("7to1", 1, 1, 0, 0, 0, 0);
    ticks(1, 3, 4'd1, 1'b1);   hand("retire", 0, 0, 1, 5, 0, 0);

    // fill all slots at slow speed, then drain them quickly
    ticks(400, 2, 4'd1, 1'b1);
    ticks(80, 2, 4'd15, 1'b1);

    // halt: frame ticks with run low change nothing, then resume
    ticks(150, 2, 4'd1, 1'b1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    ticks(100, 2, 4'd15, 1'b0);
    ticks(20, 2, 4'd3, 1'b1);

    // clear together with a tick: clear wins, then next spawn on tick 41
    ticks(100, 2, 4'd1, 1'b1);
    step(0, 1, 1, 1, 1);       hand("clear", 0, 0, 1, 5, 1, 0);
    ticks(40, 2, 4'd4, 1'b1);  hand("clr_pre", 0, 0, 1, 5, 1, 0);
    step(0, 1, 1, 0, 4);       hand("clr_spawn", T_SPAWN_X, 1, 0, 0, 1, 1);

    // reset mid-game, then spawn again on tick 41
    ticks(10, 2, 4'd4, 1'b1);
    step(1, 1, 1, 0, 4);       hand("mid_rst", 0, 0, 1, 5, 1, 0);
    step(0, 0, 1, 0, 4);
    ticks(40, 2, 4'd4, 1'b1);  hand("rst_pre", 0, 0, 1, 5, 1, 0);
    step(0, 1, 1, 0, 4);       hand("rst_spawn", T_SPAWN_X, 1, 0, 0, 1, 1);

    // long run for type statistics (a tick every cycle)
    ticks(22000, 1, 4'd15, 1'b1);
    step(0, 0, 1, 0, 15);
    step(0, 0, 1, 0, 15);
    @(posedge clk); #5;

    chk("drain", cyc_cnt, 32'(q.size()), 32'd0);
`ifdef DANGER_BIRD_EN
    chk("types_seen", cyc_cnt, 32'(seen[5:0]), 32'h1F);
`else
    chk("types_seen", cyc_cnt, 32'(seen[5:0]), 32'h1C);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
